// File: rtl/demux4_tdm.sv
// rtl/demux4_tdm.sv - TDM 1:4 receive demultiplexer with frame hunt/lock and framing error flag
module demux4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  output logic             frame_done,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic [3:0]       y_valid_q, y_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;

  // Next-state: hunt for a sync beat, then steer each beat to its slot and police sync placement
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    for (int i = 0; i < 4; i++) y_d[i] = y_q[i];
    y_valid_d    = 4'b0000;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (sync) begin
            y_d[0]    = din;
            y_valid_d = 4'b0001;
            slot_d    = 2'd1;
            state_d   = ST_LOCKED;
          end
        end
        default: begin
          if (sync) begin
            // A sync anywhere but slot 0 realigns the frame on this beat
            sync_err_d = (slot_q != 2'd0);
            y_d[0]     = din;
            y_valid_d  = 4'b0001;
            slot_d     = 2'd1;
          end else if (slot_q == 2'd0) begin
            // Missing sync at frame start: drop the beat and go back to hunting
            sync_err_d = 1'b1;
            slot_d     = 2'd0;
            state_d    = ST_HUNT;
          end else begin
            y_d[slot_q]       = din;
            y_valid_d[slot_q] = 1'b1;
            frame_done_d      = (slot_q == 2'd3);
            slot_d            = slot_q + 2'd1;
          end
        end
      endcase
    end
  end

  // State, channel holding registers and pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      slot_q       <= 2'd0;
      for (int i = 0; i < 4; i++) y_q[i] <= '0;
      y_valid_q    <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      for (int i = 0; i < 4; i++) y_q[i] <= y_d[i];
      y_valid_q    <= y_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign y0         = y_q[0];
  assign y1         = y_q[1];
  assign y2         = y_q[2];
  assign y3         = y_q[3];
  assign y_valid    = y_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == ST_LOCKED);
  assign slot       = slot_q;

endmodule

// File: tb/tb_demux4_tdm.sv
// tb/tb_demux4_tdm.sv - self-checking bench for demux4_tdm
module tb_demux4_tdm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       sync;
  logic [7:0] y0, y1, y2, y3;
  logic [3:0] y_valid;
  logic       frame_done, locked, sync_err;
  logic [1:0] slot;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int  m_locked;
  int  m_slot;
  int  m_y [4];
  int  m_yv;
  int  m_fd;
  int  m_err;
  int  fd_count;

  demux4_tdm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y_valid(y_valid),
    .frame_done(frame_done), .locked(locked), .slot(slot), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".y0"}, {24'd0, y0}, m_y[0]);
    chk({tag, ".y1"}, {24'd0, y1}, m_y[1]);
    chk({tag, ".y2"}, {24'd0, y2}, m_y[2]);
    chk({tag, ".y3"}, {24'd0, y3}, m_y[3]);
    chk({tag, ".y_valid"}, {28'd0, y_valid}, m_yv);
    chk({tag, ".frame_done"}, {31'd0, frame_done}, m_fd);
    chk({tag, ".locked"}, {31'd0, locked}, m_locked);
    chk({tag, ".slot"}, {30'd0, slot}, m_slot);
    chk({tag, ".sync_err"}, {31'd0, sync_err}, m_err);
  endtask

  task automatic model_reset();
    m_locked = 0; m_slot = 0; m_yv = 0; m_fd = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_y[i] = 0;
  endtask

  // Frame rules: slot 0 must carry sync; sync elsewhere realigns; missing sync drops lock
  task automatic model_step(input int v, input int s, input int d);
    m_yv = 0; m_fd = 0; m_err = 0;
    if (v != 0) begin
      if (m_locked == 0) begin
        if (s != 0) begin
          m_y[0] = d; m_yv = 1; m_slot = 1; m_locked = 1;
        end
      end else if (s != 0) begin
        m_err = (m_slot != 0) ? 1 : 0;
        m_y[0] = d; m_yv = 1; m_slot = 1;
      end else if (m_slot == 0) begin
        m_err = 1; m_locked = 0;
      end else begin
        m_y[m_slot] = d;
        m_yv = 1 << m_slot;
        m_fd = (m_slot == 3) ? 1 : 0;
        m_slot = (m_slot + 1) % 4;
      end
    end
    if (m_fd != 0) fd_count++;
  endtask

  task automatic step(input string tag, input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    din_valid = v; sync = s; din = d;
    @(posedge clk);
    model_step(int'(v), int'(s), int'(d));
    #1;
    chk_all(tag);
  endtask

  initial begin
    int fd_start;
    logic v, s;
    logic [7:0] d;
    rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
    model_reset();
    fd_count = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-frame, observed before the next clock edge
    step("t1_b0", 1'b1, 1'b1, 8'h11);
    step("t1_b1", 1'b1, 1'b0, 8'h22);
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("t1_async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Aligned frame
    step("t2_a", 1'b1, 1'b1, 8'hA1);
    step("t2_b", 1'b1, 1'b0, 8'hB2);
    step("t2_c", 1'b1, 1'b0, 8'hC3);
    step("t2_d", 1'b1, 1'b0, 8'hD4);
    chk("t2_frame_done", {31'd0, frame_done}, 1);
    step("t2_idle", 1'b0, 1'b0, 8'h00);

    // Hunt from reset
    @(negedge clk); rst = 1'b1; #1; model_reset();
    @(negedge clk); rst = 1'b0;
    step("t3_55", 1'b1, 1'b0, 8'h55);
    step("t3_66", 1'b1, 1'b0, 8'h66);
    step("t3_77", 1'b1, 1'b1, 8'h77);
    chk("t3_y0", {24'd0, y0}, 32'h77);

    // Gaps within a frame
    step("t3_fill2", 1'b1, 1'b0, 8'h01);
    step("t3_fill3", 1'b1, 1'b0, 8'h02);
    step("t3_fill4", 1'b1, 1'b0, 8'h03);
    fd_start = fd_count;
    step("t4_10", 1'b1, 1'b1, 8'h10);
    step("t4_g1", 1'b0, 1'b0, 8'hFF);
    step("t4_20", 1'b1, 1'b0, 8'h20);
    step("t4_g2", 1'b0, 1'b1, 8'hFF);
    step("t4_g3", 1'b0, 1'b0, 8'hFF);
    step("t4_30", 1'b1, 1'b0, 8'h30);
    step("t4_40", 1'b1, 1'b0, 8'h40);
    step("t4_idle", 1'b0, 1'b0, 8'h00);
    chk("t4_fd_once", fd_count - fd_start, 1);

    // Early sync
    step("t5_01", 1'b1, 1'b1, 8'h01);
    step("t5_02", 1'b1, 1'b0, 8'h02);
    step("t5_03", 1'b1, 1'b1, 8'h03);
    chk("t5_sync_err", {31'd0, sync_err}, 1);
    step("t5_idle", 1'b0, 1'b0, 8'h00);

    // Missing sync after a full frame
    step("t6_f1", 1'b1, 1'b0, 8'h04);
    step("t6_f2", 1'b1, 1'b0, 8'h05);
    step("t6_f3", 1'b1, 1'b0, 8'h06);
    step("t6_ee", 1'b1, 1'b0, 8'hEE);
    chk("t6_unlocked", {31'd0, locked}, 0);
    step("t6_aa", 1'b1, 1'b1, 8'hAA);

    // Randomized traffic, sync mostly placed correctly
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 8) s = (m_slot == 0);
      else s = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      step("rand", v, s, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
